fir_tap_mac: RTL

Serial 64-tap FIR multiply-accumulate stage for one equalizer band. Consumes the 6-bit phase count and step enable driving the band's sequencing. Performs one tap product per enabled cycle and emits one filtered sample per 64-step frame. Sits between the tap-phase counter plus coefficient ROM upstream and the band gain/summing stage downstream.

---
 rtl/eq_pkg.sv | 34 +++
 rtl/fir_delay_line.sv | 37 +++
 rtl/fir_tap_mac.sv | 72 +++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Equalizer band shared types and constants.
// Widths, tap count and output rounding/saturation.
package eq_pkg;

  localparam int TAPS    = 64;
  localparam int CNT_W   = $clog2(TAPS);
  localparam int DATA_W  = 16;
  localparam int COEFF_W = 16;
  localparam int FRAC_W  = COEFF_W - 1;
  localparam int PROD_W  = DATA_W + COEFF_W;
  localparam int ACC_W   = PROD_W + 6;

  localparam logic signed [ACC_W:0] SAT_MAX =
    (ACC_W+1)'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN =
    (ACC_W+1)'(-(2**(DATA_W-1)));
  localparam logic signed [ACC_W:0] RND_BIAS =
    (ACC_W+1)'(2**(FRAC_W-1));

  // Round half up, drop the Q1.15 fraction, clamp.
  function automatic logic signed [DATA_W-1:0]
    round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] r;
    r = $signed({acc[ACC_W-1], acc}) + RND_BIAS;
    r = r >>> FRAC_W;
    if (r > SAT_MAX)
      return SAT_MAX[DATA_W-1:0];
    else if (r < SAT_MIN)
      return SAT_MIN[DATA_W-1:0];
    else
      return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// 64-entry sample history with a frame write pointer.
// Tap k reads x[n-k]; tap 0 bypasses the incoming sample.
module fir_delay_line
  import eq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     adv,
  input  logic [CNT_W-1:0]         rd_k,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [TAPS];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_addr;

  assign rd_addr = wr_ptr - rd_k;
  assign rd_data = (rd_k == '0) ? wr_data
                                : mem[rd_addr];

  // Store new sample at frame start; advance at frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++)
        mem[i] <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en)
        mem[wr_ptr] <= wr_data;
      if (adv)
        wr_ptr <= wr_ptr + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fir_tap_mac.sv
// Serial 64-tap FIR MAC for one equalizer band.
// One tap product per enabled cycle, one sample per frame.
module fir_tap_mac
  import eq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_enable,
  input  logic [CNT_W-1:0]          current_count,
  input  logic signed [COEFF_W-1:0] coeff_in,
  input  logic signed [DATA_W-1:0]  filter_in,
  output logic signed [DATA_W-1:0]  filter_out,
  output logic                      filter_out_valid
);

  logic                     step_first;
  logic                     step_last;
  logic                     primed;
  logic                     done;
  logic signed [DATA_W-1:0] tap;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;

  assign step_first = clk_enable &&
    (current_count == '0);
  assign step_last  = clk_enable &&
    (current_count == CNT_W'(TAPS-1));

  fir_delay_line u_dl (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (step_first),
    .wr_data (filter_in),
    .adv     (step_last),
    .rd_k    (current_count),
    .rd_data (tap)
  );

  assign prod     = tap * coeff_in;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Accumulate; tap 0 restarts the sum and arms output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      primed <= 1'b0;
    end else if (clk_enable) begin
      if (step_first) begin
        acc    <= prod_ext;
        primed <= 1'b1;
      end else begin
        acc <= acc + prod_ext;
      end
    end
  end

  // A completed frame publishes on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done             <= 1'b0;
      filter_out       <= '0;
      filter_out_valid <= 1'b0;
    end else begin
      done             <= step_last && primed;
      filter_out_valid <= done;
      if (done)
        filter_out <= round_sat(acc);
    end
  end

endmodule
